spmat_lane_packer: RTL and testbench
====================================

// Module: spmat_lane_packer
// PURPOSE
//  Producer side of the 4-lane sparse-matrix stream consumed by mat_multi.
//  Accepts one complex nonzero per handshake (column index, value, end-of-row flag).
//  Packs nonzeros into 4-lane groups; a group ends at lane 3 or at end of row.
//  Emits each group on the S_* interface (Scol_index, S_val_*, S_vld_o/S_rdy_o)
//  with zero padding in unused lanes.
// PARAMETERS
//  MAT_RANK  256  matrix dimension; IW = $clog2(MAT_RANK) = index width
// PORTS
//  clk         in   1     clock, all state on rising edge
//  rst_n       in   1     reset, asynchronous assert, active-low
//  nz_col      in   IW    column index of incoming nonzero
//  nz_val_i    in   32    imaginary part
//  nz_val_r    in   32    real part
//  nz_last     in   1     this element ends the current row
//  nz_empty    in   1     row has no nonzeros: element carries no data; requires nz_last=1
//  nz_vld      in   1     input valid
//  nz_rdy      out  1     input ready
//  Scol_index  out  4*IW  lane k index at [k*IW +: IW]
//  S_val_i0..3 out  32    lane 0..3 imaginary
//  S_val_r0..3 out  32    lane 0..3 real
//  S_lane_vld  out  4     lane k holds a real nonzero
//  S_last      out  1     group ends a row
//  S_row       out  IW    row number of group
//  S_vld_o     out  1     group valid
//  S_rdy_o     in   1     consumer ready
//  nnz_cnt     out  32    only with SPMAT_NNZ_CNT_EN
// BEHAVIOUR
//  - Two stages: gather regs (lane cnt 0..3, gather_full flag, row_cnt) -> output regs.
//  - Input accept: nz_vld && nz_rdy.
//    - nz_rdy = !gather_full || load. Combinational from S_rdy_o; never depends on nz_vld.
//    - load = gather_full && (!S_vld_o || S_rdy_o).
//  - On accept with nz_empty=0:
//    - Write lane cnt (col, val); set lane_vld[cnt].
//    - If cnt==3 or nz_last: set gather_full; else cnt++.
//  - On accept with nz_empty=1:
//    - No lane written; set gather_full.
//    - Group emits with S_lane_vld=0000, S_last=1.
//  - On load (edge):
//    - Output regs <= gather; unwritten lanes output col=0, val=0.
//    - S_vld_o<=1; S_last<=group's last flag; S_row<=row_cnt.
//    - Clear gather, cnt<=0, lane_vld<=0.
//    - If the group has last: row_cnt++, wrapping MAT_RANK-1 -> 0.
//  - Same-cycle load + accept: accepted element goes to lane 0 of the fresh gather.
//    Sustained 1 nonzero/cycle when S_rdy_o=1.
//  - Output handshake:
//    - S_vld_o held, data stable, until S_vld_o && S_rdy_o.
//    - On that edge, S_vld_o<=0 unless a load occurs the same edge.
//  - Latency: completing element accepted at edge t -> S_vld_o=1 after edge t+1, when output free.
//  - Backpressure: S_rdy_o=0 with both stages full -> nz_rdy=0; no loss, no reorder.
//  - nz_empty=1 with nz_last=0 is illegal; treat as nz_last=1.
//  - Reset (async, any time): every output 0 (S_vld_o=0, nz_rdy=1 after release).
//    cnt, row_cnt, gather_full, lane_vld cleared; partial groups discarded.
// CONFIGURATION
//  SPMAT_NNZ_CNT_EN defined:
//    - Port nnz_cnt present; reset 0.
//    - +1 per accept with nz_empty=0; saturates at 32'hFFFF_FFFF.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  - Row of 4 nonzeros, cols 3,7,9,200, S_rdy_o=1:
//    one group, S_lane_vld=1111, S_last=1, S_row=0, 2 cycles after last accept.
//  - Row of 6 nonzeros:
//    group A lane_vld=1111 S_last=0, then group B lane_vld=0011 S_last=1;
//    B lanes 2-3 col=0 val=0.
//  - nz_empty row, then 1-nonzero row:
//    group lane_vld=0000 S_last=1 S_row=0, then lane_vld=0001 S_row=1.
//  - S_rdy_o=0 for 20 cycles during 12-nonzero stream:
//    nz_rdy falls after 8 accepts; all 3 groups later delivered in order, data intact.
//  - MAT_RANK=4, 5 single-nonzero rows: S_row sequence 0,1,2,3,0.
//  - rst_n low mid-row (2 lanes gathered, S_vld_o=1):
//    outputs 0 immediately; next row emits from lane 0 with S_row=0.
//    SPMAT_NNZ_CNT_EN build: nnz_cnt=0 after reset, =N after N nonzeros.

Source files
------------

// File: rtl/spmat_lane_packer_if.sv
// Nonzero input stream (nz_*) and 4-lane packed group output stream (S_*) of spmat_lane_packer.
// slave is the packer's view; master is the producer/consumer environment's view.
interface spmat_lane_packer_if #(
    parameter int IW = 8
);
    logic [IW-1:0]   nz_col;
    logic [31:0]     nz_val_i;
    logic [31:0]     nz_val_r;
    logic            nz_last;
    logic            nz_empty;
    logic            nz_vld;
    logic            nz_rdy;

    logic [4*IW-1:0] Scol_index;
    logic [31:0]     S_val_i0;
    logic [31:0]     S_val_i1;
    logic [31:0]     S_val_i2;
    logic [31:0]     S_val_i3;
    logic [31:0]     S_val_r0;
    logic [31:0]     S_val_r1;
    logic [31:0]     S_val_r2;
    logic [31:0]     S_val_r3;
    logic [3:0]      S_lane_vld;
    logic            S_last;
    logic [IW-1:0]   S_row;
    logic            S_vld_o;
    logic            S_rdy_o;

    modport slave (
        input  nz_col, nz_val_i, nz_val_r, nz_last, nz_empty, nz_vld,
        output nz_rdy,
        output Scol_index, S_val_i0, S_val_i1, S_val_i2, S_val_i3,
        output S_val_r0, S_val_r1, S_val_r2, S_val_r3,
        output S_lane_vld, S_last, S_row, S_vld_o,
        input  S_rdy_o
    );

    modport master (
        output nz_col, nz_val_i, nz_val_r, nz_last, nz_empty, nz_vld,
        input  nz_rdy,
        input  Scol_index, S_val_i0, S_val_i1, S_val_i2, S_val_i3,
        input  S_val_r0, S_val_r1, S_val_r2, S_val_r3,
        input  S_lane_vld, S_last, S_row, S_vld_o,
        output S_rdy_o
    );
endinterface

// File: rtl/spmat_lane_packer.sv
// Packs complex nonzeros into 4-lane row groups: gather stage -> output stage, 1 nonzero/cycle sustained.
// Optional SPMAT_NNZ_CNT_EN adds a saturating nnz_cnt port counting accepted non-empty elements.
module spmat_lane_packer #(
    parameter int MAT_RANK = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    spmat_lane_packer_if.slave  io
`ifdef SPMAT_NNZ_CNT_EN
    ,
    output logic [31:0]         nnz_cnt
`endif
);
    localparam int IW = $clog2(MAT_RANK);

    logic [1:0]            cnt;
    logic                  gather_full;
    logic [3:0][IW-1:0]    g_col;
    logic [3:0][31:0]      g_vi;
    logic [3:0][31:0]      g_vr;
    logic [3:0]            g_lvld;
    logic                  g_last;
    logic [IW-1:0]         row_cnt;

    logic [3:0][IW-1:0]    o_col;
    logic [3:0][31:0]      o_vi;
    logic [3:0][31:0]      o_vr;
    logic [3:0]            o_lvld;
    logic                  o_last;
    logic [IW-1:0]         o_row;
    logic                  o_vld;

    logic                  load;
    logic                  accept;
    logic                  elem_last;
    logic [1:0]            wr_lane;

    assign load      = gather_full && (!o_vld || io.S_rdy_o);
    assign io.nz_rdy = !gather_full || load;
    assign accept    = io.nz_vld && io.nz_rdy;
    // An empty-row marker always closes its row, even if nz_last was left low.
    assign elem_last = io.nz_last || io.nz_empty;
    // Accepting while full only happens alongside a load, so the element opens a fresh group.
    assign wr_lane   = gather_full ? 2'd0 : cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            gather_full <= 1'b0;
            g_col       <= '0;
            g_vi        <= '0;
            g_vr        <= '0;
            g_lvld      <= '0;
            g_last      <= 1'b0;
            row_cnt     <= '0;
        end else begin
            if (load) begin
                cnt         <= '0;
                gather_full <= 1'b0;
                g_col       <= '0;
                g_vi        <= '0;
                g_vr        <= '0;
                g_lvld      <= '0;
                g_last      <= 1'b0;
                if (g_last) begin
                    row_cnt <= (row_cnt == IW'(MAT_RANK - 1)) ? '0 : row_cnt + 1'b1;
                end
            end
            if (accept) begin
                if (!io.nz_empty) begin
                    g_col[wr_lane]  <= io.nz_col;
                    g_vi[wr_lane]   <= io.nz_val_i;
                    g_vr[wr_lane]   <= io.nz_val_r;
                    g_lvld[wr_lane] <= 1'b1;
                end
                if (wr_lane == 2'd3 || elem_last) begin
                    gather_full <= 1'b1;
                    g_last      <= elem_last;
                end else begin
                    cnt <= wr_lane + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_col  <= '0;
            o_vi   <= '0;
            o_vr   <= '0;
            o_lvld <= '0;
            o_last <= 1'b0;
            o_row  <= '0;
            o_vld  <= 1'b0;
        end else if (load) begin
            o_col  <= g_col;
            o_vi   <= g_vi;
            o_vr   <= g_vr;
            o_lvld <= g_lvld;
            o_last <= g_last;
            o_row  <= row_cnt;
            o_vld  <= 1'b1;
        end else if (o_vld && io.S_rdy_o) begin
            o_vld  <= 1'b0;
        end
    end

    assign io.Scol_index = o_col;
    assign io.S_val_i0   = o_vi[0];
    assign io.S_val_i1   = o_vi[1];
    assign io.S_val_i2   = o_vi[2];
    assign io.S_val_i3   = o_vi[3];
    assign io.S_val_r0   = o_vr[0];
    assign io.S_val_r1   = o_vr[1];
    assign io.S_val_r2   = o_vr[2];
    assign io.S_val_r3   = o_vr[3];
    assign io.S_lane_vld = o_lvld;
    assign io.S_last     = o_last;
    assign io.S_row      = o_row;
    assign io.S_vld_o    = o_vld;

`ifdef SPMAT_NNZ_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nnz_cnt <= '0;
        end else if (accept && !io.nz_empty && nnz_cnt != 32'hFFFF_FFFF) begin
            nnz_cnt <= nnz_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_spmat_lane_packer.sv
// Bench for spmat_lane_packer: random rows and backpressure checked against a queue-based group model.
module tb_spmat_lane_packer;
    localparam int MAT_RANK = 256;
    localparam int IW = $clog2(MAT_RANK);

    typedef struct packed {
        logic [IW-1:0] col;
        logic [31:0]   vi;
        logic [31:0]   vr;
    } lane_t;

    typedef struct packed {
        logic [4*IW-1:0]  col;
        logic [3:0][31:0] vi;
        logic [3:0][31:0] vr;
        logic [3:0]       lvld;
        logic             last;
        logic [IW-1:0]    row;
    } grp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spmat_lane_packer_if #(.IW(IW)) io ();
    spmat_lane_packer_if #(.IW(2))  io4 ();

`ifdef SPMAT_NNZ_CNT_EN
    logic [31:0] nnz_cnt;
    logic [31:0] nnz_cnt4;
`endif

    spmat_lane_packer #(.MAT_RANK(MAT_RANK)) dut (
        .clk(clk), .rst_n(rst_n), .io(io)
`ifdef SPMAT_NNZ_CNT_EN
        , .nnz_cnt(nnz_cnt)
`endif
    );

    spmat_lane_packer #(.MAT_RANK(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .io(io4)
`ifdef SPMAT_NNZ_CNT_EN
        , .nnz_cnt(nnz_cnt4)
`endif
    );

    int    n_cmp = 0;
    int    n_fail = 0;
    int    n_acc = 0;
    int    mdl_row = 0;
    int    mdl_nnz = 0;
    logic  bp_rand = 1'b0;
    logic  rdy_force = 1'b1;
    lane_t pend[$];
    grp_t  exp_q[$];
    grp_t  obs_q[$];

    // Reference: a group closes at 4 lanes, at end of row, or at an empty-row marker.
    function automatic void model_accept(lane_t e, logic last, logic empty);
        grp_t g;
        if (!empty) begin
            pend.push_back(e);
            mdl_nnz++;
        end
        if (empty || last || pend.size() == 4) begin
            g = '0;
            foreach (pend[k]) begin
                g.col[k*IW +: IW] = pend[k].col;
                g.vi[k]   = pend[k].vi;
                g.vr[k]   = pend[k].vr;
                g.lvld[k] = 1'b1;
            end
            g.last = 1'b1 & (empty | last);
            g.row  = IW'(mdl_row);
            exp_q.push_back(g);
            pend.delete();
            if (g.last) mdl_row = (mdl_row + 1) % MAT_RANK;
        end
    endfunction

    always @(negedge clk) begin
        grp_t g;
        if (rst_n) begin
            if (io.nz_vld && io.nz_rdy) begin
                model_accept({io.nz_col, io.nz_val_i, io.nz_val_r}, io.nz_last, io.nz_empty);
                n_acc++;
            end
            if (io.S_vld_o && io.S_rdy_o) begin
                g.col  = io.Scol_index;
                g.vi   = {io.S_val_i3, io.S_val_i2, io.S_val_i1, io.S_val_i0};
                g.vr   = {io.S_val_r3, io.S_val_r2, io.S_val_r1, io.S_val_r0};
                g.lvld = io.S_lane_vld;
                g.last = io.S_last;
                g.row  = io.S_row;
                obs_q.push_back(g);
            end
        end
    end

    initial begin
        io.S_rdy_o = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            io.S_rdy_o = bp_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

    function automatic void clear_model();
        exp_q.delete();
        obs_q.delete();
        pend.delete();
        mdl_row = 0;
        mdl_nnz = 0;
        n_acc   = 0;
    endfunction

    task automatic send(input logic [IW-1:0] col, input logic [31:0] vi, input logic [31:0] vr,
                        input logic last, input logic empty);
        int n = 0;
        io.nz_col = col; io.nz_val_i = vi; io.nz_val_r = vr;
        io.nz_last = last; io.nz_empty = empty; io.nz_vld = 1'b1;
        @(negedge clk);
        while (!io.nz_rdy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!io.nz_rdy) begin
            n_cmp++; n_fail++;
            $display("FAIL send_timeout: nz_rdy=%0b after %0d cycles, required 1", io.nz_rdy, n);
        end
        @(posedge clk);
        #1;
        io.nz_vld = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        bp_rand = 1'b0;
        rdy_force = 1'b1;
        while (obs_q.size() < exp_q.size() && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        if (obs_q.size() < exp_q.size()) begin
            n_cmp++; n_fail++;
            $display("FAIL drain_timeout: %0d groups seen, required %0d", obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset();
        io.nz_vld = 1'b0; io.nz_col = '0; io.nz_val_i = '0; io.nz_val_r = '0;
        io.nz_last = 1'b0; io.nz_empty = 1'b0;
        io4.nz_vld = 1'b0; io4.nz_col = '0; io4.nz_val_i = '0; io4.nz_val_r = '0;
        io4.nz_last = 1'b0; io4.nz_empty = 1'b0; io4.S_rdy_o = 1'b1;
        rst_n = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({io.S_vld_o, io.S_last, io.S_lane_vld, io.S_row, io.Scol_index} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: vld=%0b last=%0b lvld=%b row=%0d col=%h, required all 0",
                     io.S_vld_o, io.S_last, io.S_lane_vld, io.S_row, io.Scol_index);
        end
        n_cmp++;
        if ({io.S_val_i0, io.S_val_i1, io.S_val_i2, io.S_val_i3,
             io.S_val_r0, io.S_val_r1, io.S_val_r2, io.S_val_r3} !== '0) begin
            n_fail++;
            $display("FAIL reset_vals: lane values nonzero (i0=%h r0=%h), required 0", io.S_val_i0, io.S_val_r0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (io.nz_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_rdy: nz_rdy=%0b, required 1", io.nz_rdy);
        end
`ifdef SPMAT_NNZ_CNT_EN
        n_cmp++;
        if (nnz_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_nnz: nnz_cnt=%0d, required 0", nnz_cnt);
        end
`endif
    endtask

    task automatic test_basic_row();
        exp_q.delete(); obs_q.delete();
        send(IW'(3),   $urandom, $urandom, 1'b0, 1'b0);
        send(IW'(7),   $urandom, $urandom, 1'b0, 1'b0);
        send(IW'(9),   $urandom, $urandom, 1'b0, 1'b0);
        send(IW'(200), $urandom, $urandom, 1'b1, 1'b0);
        n_cmp++;
        if (io.S_vld_o !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_early: S_vld_o=%0b right after final accept, required 0", io.S_vld_o);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({io.S_vld_o, io.S_lane_vld, io.S_last, io.S_row} !== {1'b1, 4'b1111, 1'b1, IW'(0)}) begin
            n_fail++;
            $display("FAIL basic_group: vld=%0b lvld=%b last=%0b row=%0d, required 1 1111 1 0",
                     io.S_vld_o, io.S_lane_vld, io.S_last, io.S_row);
        end
        n_cmp++;
        if (io.Scol_index !== {IW'(200), IW'(9), IW'(7), IW'(3)}) begin
            n_fail++;
            $display("FAIL basic_cols: Scol_index=%h, required cols 3,7,9,200", io.Scol_index);
        end
        wait_drain();
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL basic_count: %0d groups, required %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            n_cmp++;
            if (obs_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL basic_grp%0d: got %h required %h", k, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_six_split();
        exp_q.delete(); obs_q.delete();
        for (int i = 0; i < 6; i++) begin
            send(IW'($urandom), $urandom, $urandom, i == 5, 1'b0);
        end
        wait_drain();
        n_cmp++;
        if ({obs_q[0].lvld, obs_q[0].last, obs_q[1].lvld, obs_q[1].last} !== {4'b1111, 1'b0, 4'b0011, 1'b1}) begin
            n_fail++;
            $display("FAIL six_shape: A lvld=%b last=%0b B lvld=%b last=%0b, required 1111 0 0011 1",
                     obs_q[0].lvld, obs_q[0].last, obs_q[1].lvld, obs_q[1].last);
        end
        n_cmp++;
        if ({obs_q[1].col[4*IW-1:2*IW], obs_q[1].vi[3], obs_q[1].vi[2], obs_q[1].vr[3], obs_q[1].vr[2]} !== '0) begin
            n_fail++;
            $display("FAIL six_pad: B lanes 2-3 col=%h vi3=%h vr3=%h, required 0",
                     obs_q[1].col[4*IW-1:2*IW], obs_q[1].vi[3], obs_q[1].vr[3]);
        end
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL six_count: %0d groups, required %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            n_cmp++;
            if (obs_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL six_grp%0d: got %h required %h", k, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_empty_row();
        exp_q.delete(); obs_q.delete();
        send('0, '0, '0, 1'b1, 1'b1);
        send(IW'(5), $urandom, $urandom, 1'b1, 1'b0);
        wait_drain();
        // Rows 0 and 1 were consumed by the two previous scenarios.
        n_cmp++;
        if ({obs_q[0].lvld, obs_q[0].last, obs_q[0].row} !== {4'b0000, 1'b1, IW'(2)}) begin
            n_fail++;
            $display("FAIL empty_group: lvld=%b last=%0b row=%0d, required 0000 1 2",
                     obs_q[0].lvld, obs_q[0].last, obs_q[0].row);
        end
        n_cmp++;
        if ({obs_q[1].lvld, obs_q[1].last, obs_q[1].row} !== {4'b0001, 1'b1, IW'(3)}) begin
            n_fail++;
            $display("FAIL empty_next: lvld=%b last=%0b row=%0d, required 0001 1 3",
                     obs_q[1].lvld, obs_q[1].last, obs_q[1].row);
        end
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL empty_count: %0d groups, required %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            n_cmp++;
            if (obs_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL empty_grp%0d: got %h required %h", k, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        int a0;
        exp_q.delete(); obs_q.delete();
        rdy_force = 1'b0;
        @(posedge clk);
        #1;
        a0 = n_acc;
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    send(IW'($urandom), $urandom, $urandom, i == 11, 1'b0);
                end
            end
            begin
                repeat (20) @(posedge clk);
                #1;
                n_cmp++;
                if (n_acc - a0 !== 8) begin
                    n_fail++;
                    $display("FAIL bp_accepts: %0d accepted while stalled, required 8", n_acc - a0);
                end
                n_cmp++;
                if ({io.nz_rdy, io.S_vld_o} !== 2'b01) begin
                    n_fail++;
                    $display("FAIL bp_stall: nz_rdy=%0b S_vld_o=%0b, required 0 1", io.nz_rdy, io.S_vld_o);
                end
                rdy_force = 1'b1;
            end
        join
        wait_drain();
        n_cmp++;
        if (obs_q.size() !== 3 || exp_q.size() !== 3) begin
            n_fail++;
            $display("FAIL bp_count: %0d groups seen, %0d modelled, required 3", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            n_cmp++;
            if (obs_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL bp_grp%0d: got %h required %h", k, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_random_stream();
        int len;
        exp_q.delete(); obs_q.delete();
        bp_rand = 1'b1;
        for (int r = 0; r < 40; r++) begin
            len = $urandom_range(0, 9);
            if (len == 0) begin
                send('0, '0, '0, 1'($urandom_range(0, 1)), 1'b1);
            end else begin
                for (int i = 0; i < len; i++) begin
                    send(IW'($urandom), $urandom, $urandom, i == len - 1, 1'b0);
                end
            end
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        wait_drain();
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_count: %0d groups, required %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            n_cmp++;
            if (obs_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL rand_grp%0d: got %h required %h", k, obs_q[k], exp_q[k]);
            end
        end
`ifdef SPMAT_NNZ_CNT_EN
        n_cmp++;
        if (nnz_cnt !== 32'(mdl_nnz)) begin
            n_fail++;
            $display("FAIL rand_nnz: nnz_cnt=%0d, required %0d", nnz_cnt, mdl_nnz);
        end
`endif
    endtask

    task automatic test_rank_wrap();
        logic [1:0] rows[$];
        int         exp_rows[5] = '{0, 1, 2, 3, 0};
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    io4.nz_col = 2'($urandom); io4.nz_val_i = $urandom; io4.nz_val_r = $urandom;
                    io4.nz_last = 1'b1; io4.nz_empty = 1'b0; io4.nz_vld = 1'b1;
                    @(posedge clk);
                    #1;
                end
                io4.nz_vld = 1'b0;
            end
            begin
                repeat (15) begin
                    @(negedge clk);
                    if (io4.S_vld_o && io4.S_rdy_o) rows.push_back(io4.S_row);
                end
            end
        join
        n_cmp++;
        if (rows.size() !== 5) begin
            n_fail++;
            $display("FAIL wrap_count: %0d groups, required 5", rows.size());
        end
        for (int k = 0; k < rows.size() && k < 5; k++) begin
            n_cmp++;
            if (int'(rows[k]) !== exp_rows[k]) begin
                n_fail++;
                $display("FAIL wrap_row%0d: S_row=%0d, required %0d", k, rows[k], exp_rows[k]);
            end
        end
    endtask

    task automatic test_reset_mid_row();
        exp_q.delete(); obs_q.delete();
        rdy_force = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            send(IW'($urandom), $urandom, $urandom, 1'b0, 1'b0);
        end
        n_cmp++;
        if (io.S_vld_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre: S_vld_o=%0b before reset, required 1", io.S_vld_o);
        end
        #2;
        rst_n = 1'b0;
        clear_model();
        #1;
        n_cmp++;
        if ({io.S_vld_o, io.S_lane_vld, io.S_last, io.S_row, io.Scol_index, io.S_val_i0, io.S_val_r0} !== '0) begin
            n_fail++;
            $display("FAIL mid_async: vld=%0b lvld=%b col=%h i0=%h r0=%h, required all 0",
                     io.S_vld_o, io.S_lane_vld, io.Scol_index, io.S_val_i0, io.S_val_r0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rdy_force = 1'b1;
        @(posedge clk);
        #1;
`ifdef SPMAT_NNZ_CNT_EN
        n_cmp++;
        if (nnz_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_nnz0: nnz_cnt=%0d after reset, required 0", nnz_cnt);
        end
`endif
        send(IW'(11), $urandom, $urandom, 1'b0, 1'b0);
        send(IW'(22), $urandom, $urandom, 1'b0, 1'b0);
        send(IW'(33), $urandom, $urandom, 1'b1, 1'b0);
        wait_drain();
        n_cmp++;
        if ({obs_q[0].lvld, obs_q[0].last, obs_q[0].row, obs_q[0].col} !==
            {4'b0111, 1'b1, IW'(0), IW'(0), IW'(33), IW'(22), IW'(11)}) begin
            n_fail++;
            $display("FAIL mid_after: lvld=%b last=%0b row=%0d col=%h, required 0111 1 0 cols 11,22,33",
                     obs_q[0].lvld, obs_q[0].last, obs_q[0].row, obs_q[0].col);
        end
        n_cmp++;
        if (obs_q.size() !== 1 || obs_q[0] !== exp_q[0]) begin
            n_fail++;
            $display("FAIL mid_grp: %0d groups, first %h, required 1 group %h", obs_q.size(), obs_q[0], exp_q[0]);
        end
`ifdef SPMAT_NNZ_CNT_EN
        n_cmp++;
        if (nnz_cnt !== 32'd3) begin
            n_fail++;
            $display("FAIL mid_nnz: nnz_cnt=%0d, required 3", nnz_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic_row();
        test_six_split();
        test_empty_row();
        test_backpressure();
        test_random_stream();
        test_rank_wrap();
        test_reset_mid_row();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
